// File: rtl/decode_mux_arb.sv
// Decode-stage merge: arbitrates NUM_CH format decoders into one stream. The
// immediate is shifted/extended at push time, and the result is buffered in a DEPTH-entry FIFO.
module decode_mux_arb #(
  parameter int NUM_CH   = 4,
  parameter int HDR_W    = 200,
  parameter int BODY_W   = 84,
  parameter int DEPTH    = 4,
  parameter int ARB_MODE = 1,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                     clock_i,
  input  logic                     reset_ni,
  input  logic                     flush_i,
  input  logic [NUM_CH-1:0]        in_valid_i,
  output logic [NUM_CH-1:0]        in_ready_o,
  input  logic [NUM_CH*HDR_W-1:0]  in_hdr_i,
  input  logic [NUM_CH*BODY_W-1:0] in_body_i,
  input  logic [NUM_CH*2-1:0]      in_imm_mode_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [HDR_W-1:0]         out_hdr_o,
  output logic [BODY_W-1:0]        out_body_o,
  output logic [CH_W-1:0]          out_chan_o,
  output logic [CNT_W-1:0]         count_o
);

  // Body is MSB-first: body bit i lives at vector bit BODY_W-1-i, so the
  // 64b immediate field (bits 10..73) is vector [BODY_W-11 -: 64].
  localparam int IMM_MSB = BODY_W - 11;

  logic [HDR_W-1:0]  r_hdr  [DEPTH];
  logic [BODY_W-1:0] r_body [DEPTH];
  logic [CH_W-1:0]   r_chan [DEPTH];
  logic [PTR_W-1:0]  r_wr, r_rd;
  logic [CNT_W-1:0]  r_cnt;
  logic [CH_W-1:0]   r_rr;

  logic              w_gnt_any;
  logic [CH_W-1:0]   w_gnt_idx;
  logic [CH_W-1:0]   w_rr_nxt;
  logic              w_push_ok, w_push, w_pop;
  logic [BODY_W-1:0] w_body_in, w_body_proc;
  logic [1:0]        w_mode;
  logic [15:0]       w_imm16;
  int                w_idx;

  // Scan offsets high to low so the lowest offset from the base wins.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_idx     = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      w_idx = i + ((ARB_MODE == 1) ? int'(r_rr) : 0);
      if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
      if (in_valid_i[w_idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = CH_W'(w_idx);
      end
    end
  end

  assign w_rr_nxt    = (w_gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + CH_W'(1);
  assign out_valid_o = (r_cnt != '0);
  assign w_push_ok   = !flush_i && ((r_cnt < CNT_W'(DEPTH)) || (out_valid_o && out_ready_i));
  assign w_push      = reset_ni && w_gnt_any && w_push_ok;
  assign w_pop       = out_valid_o && out_ready_i && !flush_i;
  assign in_ready_o  = w_push ? (NUM_CH'(1) << w_gnt_idx) : '0;

  assign w_body_in = in_body_i[w_gnt_idx*BODY_W +: BODY_W];
  assign w_mode    = in_imm_mode_i[w_gnt_idx*2 +: 2];
  assign w_imm16   = w_body_in[IMM_MSB -: 16];

  always_comb begin
    w_body_proc = w_body_in;
    case (w_mode)
      2'b01:   w_body_proc[IMM_MSB -: 64] = {{48{w_imm16[15]}}, w_imm16};
      2'b10:   w_body_proc[IMM_MSB -: 64] = {{32{w_imm16[15]}}, w_imm16, 16'h0000};
      default: w_body_proc = w_body_in;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_rr  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_hdr[i]  <= '0;
        r_body[i] <= '0;
        r_chan[i] <= '0;
      end
    end else if (flush_i) begin
      // Flush drops queued entries but keeps arbitration fairness state.
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_hdr[r_wr]  <= in_hdr_i[w_gnt_idx*HDR_W +: HDR_W];
        r_body[r_wr] <= w_body_proc;
        r_chan[r_wr] <= w_gnt_idx;
        r_wr         <= r_wr + PTR_W'(1);
        r_rr         <= w_rr_nxt;
      end
      if (w_pop) r_rd <= r_rd + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign out_hdr_o  = r_hdr[r_rd];
  assign out_body_o = r_body[r_rd];
  assign out_chan_o = r_chan[r_rd];
  assign count_o    = r_cnt;

endmodule
